mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ex_valid_i  input  1  EX-side instruction valid this cycle.
REQ-005 SHALL have port ex_ready_o  output  1  stage can accept the EX instruction this cycle.
REQ-006 SHALL have port ex_opcode_i  input  7  opcode per the shared opcode header.
REQ-007 SHALL have port ex_funct3_i  input  3  load width/sign select.
REQ-008 SHALL have port ex_rd_i  input  5  destination register.
REQ-009 SHALL have port ex_reg_write_i  input  1  instruction writes rd.
REQ-010 SHALL have port ex_alu_result_i  input  XLEN  ALU result; for loads, the effective address.
REQ-011 SHALL have port ex_pc_plus4_i  input  XLEN  link value for JAL/JALR.
REQ-012 SHALL have port dmem_rvalid_i  input  1  load data valid.
REQ-013 SHALL have port dmem_rdata_i  input  XLEN  raw aligned-word load data.
REQ-014 SHALL have port wb_reg_write_o  output  1  register-file write enable; also the forwarding write indicator.
REQ-015 SHALL have port wb_rd_o  output  5  write-back destination.
REQ-016 SHALL have port wb_data_o  output  XLEN  write-back data; also the forwarding data.
REQ-017 SHALL have port load_pending_o  output  1  high while in WAIT_LOAD.
REQ-018 SHALL have port retired_cnt_o  output  32  count of instructions completed by this stage.

Function
REQ-019 SHALL implement FSM with states IDLE and WAIT_LOAD.
REQ-020 ex_ready_o SHALL be 1 in IDLE and 0 in WAIT_LOAD (combinational from state).
REQ-021 Accept SHALL mean ex_valid_i && ex_ready_o on a rising edge.
REQ-022 Accepted non-load SHALL register wb outputs with 1-cycle latency: wb_data_o = ex_pc_plus4_i for OPCODE_JAL/OPCODE_JALR, otherwise ex_alu_result_i.
REQ-023 Accepted OPCODE_LOAD SHALL capture rd, reg_write, funct3 and address bits [1:0], move to WAIT_LOAD, and drive wb_reg_write_o=0 next cycle.
REQ-024 In WAIT_LOAD with dmem_rvalid_i=1, SHALL register aligned load data to wb outputs on that edge and return to IDLE; ex_ready_o is high the following cycle.
REQ-025 In WAIT_LOAD with dmem_rvalid_i=0, SHALL hold state, no write-back; unbounded wait permitted.
REQ-026 dmem_rvalid_i in IDLE SHALL be ignored.
REQ-027 Alignment: LB(000) SHALL select byte addr[1:0] and sign-extend; LBU(100) zero-extend; LH(001) SHALL select halfword addr[1] and sign-extend (addr[0] ignored); LHU(101) zero-extend; LW(010) and all other funct3 SHALL pass the word unaltered.
REQ-028 wb_reg_write_o SHALL be a one-cycle pulse per completed instruction, forced 0 when captured rd==0 or reg_write==0.
REQ-029 wb_rd_o/wb_data_o SHALL hold their last values when wb_reg_write_o=0.
REQ-030 Cycles without accept and without load completion SHALL drive wb_reg_write_o=0.
REQ-031 retired_cnt_o SHALL increment by 1 per completed instruction (non-load on accept, load on data return), including rd==0 or non-writing ones, wrapping 0xFFFFFFFF->0.

Reset
REQ-032 On rst_i=1 at a clock edge: state=IDLE, wb_reg_write_o=0, wb_rd_o=0, wb_data_o=0, retired_cnt_o=0, load_pending_o=0.
REQ-033 Reset during WAIT_LOAD SHALL abandon the load, with no write-back even if dmem_rvalid_i is 1 on the same edge; reset takes priority over all events.

Verification
REQ-034 ADD rd=5 result 0x12345678 accepted -> next cycle wb_reg_write_o=1, wb_rd_o=5, wb_data_o=0x12345678, retired_cnt_o=1.
REQ-035 LB rd=3 addr=0x1003, rvalid 2 cycles later with data 0x80FF_0000 -> ex_ready_o=0 for 2 cycles, then wb_data_o=0xFFFFFF80, wb_reg_write_o=1 one cycle.
REQ-036 LHU addr=0x2 with data 0xBEEF1234 -> wb_data_o=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-037 JAL rd=1 pc_plus4=0x104 -> wb_data_o=0x104; ADD rd=0 -> wb_reg_write_o=0, retired_cnt_o still increments.
REQ-038 rst_i asserted in WAIT_LOAD coincident with rvalid -> no write pulse, IDLE, retired_cnt_o=0; 0xFFFFFFFF preload + one retire -> 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory / write-back pipeline stage. Non-load instructions
//               from EX are written back one cycle after acceptance (ALU
//               result, or PC+4 for JAL/JALR). Loads park the stage in
//               WAIT_LOAD until the data memory returns a word, which is then
//               byte/halfword aligned and sign/zero extended before being
//               written back. The write-back outputs double as the
//               forwarding source for earlier stages.
//
// Ports       : clk_i            - single clock, rising edge
//               rst_i            - synchronous active-high reset
//               ex_valid_i       - EX instruction valid
//               ex_ready_o       - stage can accept (high in IDLE)
//               ex_opcode_i      - instruction opcode
//               ex_funct3_i      - load width / sign select
//               ex_rd_i          - destination register
//               ex_reg_write_i   - instruction writes rd
//               ex_alu_result_i  - ALU result / load effective address
//               ex_pc_plus4_i    - link value for JAL/JALR
//               dmem_rvalid_i    - load data valid
//               dmem_rdata_i     - raw aligned-word load data
//               wb_reg_write_o   - register-file write enable (1-cycle pulse)
//               wb_rd_o          - write-back destination
//               wb_data_o        - write-back data
//               load_pending_o   - high while waiting for load data
//               retired_cnt_o    - instructions completed by this stage
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              ex_valid_i,
    output logic                   ex_ready_o,
    input  wire logic [6:0]        ex_opcode_i,
    input  wire logic [2:0]        ex_funct3_i,
    input  wire logic [4:0]        ex_rd_i,
    input  wire logic              ex_reg_write_i,
    input  wire logic [XLEN-1:0]   ex_alu_result_i,
    input  wire logic [XLEN-1:0]   ex_pc_plus4_i,
    input  wire logic              dmem_rvalid_i,
    input  wire logic [XLEN-1:0]   dmem_rdata_i,
    output logic                   wb_reg_write_o,
    output logic [4:0]             wb_rd_o,
    output logic [XLEN-1:0]        wb_data_o,
    output logic                   load_pending_o,
    output logic [31:0]            retired_cnt_o
);

    // Shared RV32I opcode encodings
    localparam logic [6:0] c_OPCODE_LOAD = 7'b0000011;
    localparam logic [6:0] c_OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] c_OPCODE_JALR = 7'b1100111;

    // Load funct3 encodings
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_t;

    state_t             r_state;

    // Write-back registers
    logic               r_wb_we;
    logic [4:0]         r_wb_rd;
    logic [XLEN-1:0]    r_wb_data;

    // Load context captured at accept, consumed when data returns
    logic [4:0]         r_ld_rd;
    logic               r_ld_we;
    logic [2:0]         r_ld_funct3;
    logic [1:0]         r_ld_addr;

    logic [31:0]        r_retired_cnt;

    logic               w_accept;
    logic               w_is_load;
    logic               w_is_link;
    logic               w_load_done;
    logic               w_retire;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_load_data;

    assign ex_ready_o     = (r_state == ST_IDLE);
    assign load_pending_o = (r_state == ST_WAIT_LOAD);

    assign w_accept    = ex_valid_i && ex_ready_o;
    assign w_is_load   = (ex_opcode_i == c_OPCODE_LOAD);
    assign w_is_link   = (ex_opcode_i == c_OPCODE_JAL) || (ex_opcode_i == c_OPCODE_JALR);
    assign w_load_done = (r_state == ST_WAIT_LOAD) && dmem_rvalid_i;

    // A non-load completes on accept; a load completes when its data returns
    assign w_retire    = (w_accept && !w_is_load) || w_load_done;

    // Load data alignment and extension
    always_comb begin
        w_byte      = 8'd0;
        w_half      = 16'd0;
        w_load_data = dmem_rdata_i;

        case (r_ld_addr)
            2'd0:    w_byte = dmem_rdata_i[7:0];
            2'd1:    w_byte = dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase

        // Halfword select uses addr[1] only; addr[0] is ignored
        w_half = r_ld_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

        case (r_ld_funct3)
            c_F3_LB:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_LBU: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_LH:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_LHU: w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default:  w_load_data = dmem_rdata_i;
        endcase
    end

    // Stage FSM and write-back registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_ld_rd     <= 5'd0;
            r_ld_we     <= 1'b0;
            r_ld_funct3 <= 3'd0;
            r_ld_addr   <= 2'd0;
        end else begin
            // Write enable is a single-cycle pulse; rd/data hold otherwise
            r_wb_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_load) begin
                            r_ld_rd     <= ex_rd_i;
                            r_ld_we     <= ex_reg_write_i;
                            r_ld_funct3 <= ex_funct3_i;
                            r_ld_addr   <= ex_alu_result_i[1:0];
                            r_state     <= ST_WAIT_LOAD;
                        end else if (ex_reg_write_i && (ex_rd_i != 5'd0)) begin
                            r_wb_we   <= 1'b1;
                            r_wb_rd   <= ex_rd_i;
                            r_wb_data <= w_is_link ? ex_pc_plus4_i : ex_alu_result_i;
                        end
                    end
                end

                ST_WAIT_LOAD: begin
                    if (dmem_rvalid_i) begin
                        r_state <= ST_IDLE;
                        if (r_ld_we && (r_ld_rd != 5'd0)) begin
                            r_wb_we   <= 1'b1;
                            r_wb_rd   <= r_ld_rd;
                            r_wb_data <= w_load_data;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Retired counter is rewritten every cycle so it wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retired_cnt <= 32'd0;
        end else begin
            r_retired_cnt <= r_retired_cnt + {31'd0, w_retire};
        end
    end

    assign wb_reg_write_o = r_wb_we;
    assign wb_rd_o        = r_wb_rd;
    assign wb_data_o      = r_wb_data;
    assign retired_cnt_o  = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam logic [6:0] OP_OP   = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk_i;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [6:0]  ex_opcode_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_rd_i;
    logic        ex_reg_write_i;
    logic [31:0] ex_alu_result_i;
    logic [31:0] ex_pc_plus4_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        load_pending_o;
    logic [31:0] retired_cnt_o;

    int          checks;
    int          failures;
    logic [31:0] exp_cnt;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_opcode_i     (ex_opcode_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_rd_i         (ex_rd_i),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_alu_result_i (ex_alu_result_i),
        .ex_pc_plus4_i   (ex_pc_plus4_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .wb_reg_write_o  (wb_reg_write_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .load_pending_o  (load_pending_o),
        .retired_cnt_o   (retired_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Present one instruction for a single cycle; returns at the falling
    // edge after the accepting rising edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] alu, input logic [31:0] pc4);
        ex_valid_i      = 1'b1;
        ex_opcode_i     = op;
        ex_funct3_i     = f3;
        ex_rd_i         = rd;
        ex_reg_write_i  = we;
        ex_alu_result_i = alu;
        ex_pc_plus4_i   = pc4;
        @(negedge clk_i);
        ex_valid_i      = 1'b0;
    endtask

    task automatic load_return(input logic [31:0] data);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = data;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_rd_o !== 5'd0 || wb_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_wb: we=%b rd=%0d data=%h required 0/0/0", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        checks++;
        if (retired_cnt_o !== 32'd0 || load_pending_o !== 1'b0 || ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctl: cnt=%h pend=%b ready=%b required 0/0/1", retired_cnt_o, load_pending_o, ex_ready_o);
        end
        rst_i   = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_alu;
        issue(OP_OP, 3'b000, 5'd5, 1'b1, 32'h12345678, 32'h0);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_data_o !== 32'h12345678 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL alu_wb: we=%b rd=%0d data=%h cnt=%h required 1/5/12345678/%h", wb_reg_write_o, wb_rd_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
        @(negedge clk_i);
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_rd_o !== 5'd5 || wb_data_o !== 32'h12345678 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL alu_hold: we=%b rd=%0d data=%h cnt=%h required 0/5/12345678/%h", wb_reg_write_o, wb_rd_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_load_byte;
        issue(OP_LOAD, 3'b000, 5'd3, 1'b1, 32'h00001003, 32'h0);
        checks++;
        if (ex_ready_o !== 1'b0 || load_pending_o !== 1'b1 || wb_reg_write_o !== 1'b0) begin
            failures++;
            $display("FAIL lb_wait1: ready=%b pend=%b we=%b required 0/1/0", ex_ready_o, load_pending_o, wb_reg_write_o);
        end
        @(negedge clk_i);
        checks++;
        if (ex_ready_o !== 1'b0 || wb_reg_write_o !== 1'b0 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL lb_wait2: ready=%b we=%b cnt=%h required 0/0/%h", ex_ready_o, wb_reg_write_o, retired_cnt_o, exp_cnt);
        end
        load_return(32'h80FF0000);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd3 || wb_data_o !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_data: we=%b rd=%0d data=%h required 1/3/ffffff80", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        checks++;
        if (ex_ready_o !== 1'b1 || load_pending_o !== 1'b0 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL lb_done: ready=%b pend=%b cnt=%h required 1/0/%h", ex_ready_o, load_pending_o, retired_cnt_o, exp_cnt);
        end
        // Stray rvalid while idle must be ignored
        load_return(32'hFFFFFFFF);
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_data_o !== 32'hFFFFFF80 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL idle_rvalid: we=%b data=%h cnt=%h required 0/ffffff80/%h", wb_reg_write_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_load_align;
        issue(OP_LOAD, 3'b101, 5'd7, 1'b1, 32'h00000002, 32'h0);
        load_return(32'hBEEF1234);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd7 || wb_data_o !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL lhu: we=%b rd=%0d data=%h required 1/7/0000beef", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        issue(OP_LOAD, 3'b001, 5'd8, 1'b1, 32'h00000003, 32'h0);
        load_return(32'hBEEF1234);
        exp_cnt++;
        checks++;
        if (wb_rd_o !== 5'd8 || wb_data_o !== 32'hFFFFBEEF) begin
            failures++;
            $display("FAIL lh: rd=%0d data=%h required 8/ffffbeef", wb_rd_o, wb_data_o);
        end
        issue(OP_LOAD, 3'b100, 5'd9, 1'b1, 32'h00000001, 32'h0);
        load_return(32'h00009A00);
        exp_cnt++;
        checks++;
        if (wb_data_o !== 32'h0000009A) begin
            failures++;
            $display("FAIL lbu: data=%h required 0000009a", wb_data_o);
        end
        issue(OP_LOAD, 3'b010, 5'd10, 1'b1, 32'h00000003, 32'h0);
        load_return(32'hCAFEF00D);
        exp_cnt++;
        checks++;
        if (wb_data_o !== 32'hCAFEF00D || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL lw: data=%h cnt=%h required cafef00d/%h", wb_data_o, retired_cnt_o, exp_cnt);
        end
        issue(OP_LOAD, 3'b000, 5'd0, 1'b1, 32'h00000000, 32'h0);
        load_return(32'h000000AA);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_data_o !== 32'hCAFEF00D || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL load_rd0: we=%b data=%h cnt=%h required 0/cafef00d/%h", wb_reg_write_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_jal_rd0;
        issue(OP_JAL, 3'b000, 5'd1, 1'b1, 32'h0000DEAD, 32'h00000104);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd1 || wb_data_o !== 32'h00000104) begin
            failures++;
            $display("FAIL jal: we=%b rd=%0d data=%h required 1/1/00000104", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        issue(OP_OP, 3'b000, 5'd0, 1'b1, 32'h00000055, 32'h0);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_rd_o !== 5'd1 || wb_data_o !== 32'h00000104 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL add_rd0: we=%b rd=%0d data=%h cnt=%h required 0/1/00000104/%h", wb_reg_write_o, wb_rd_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
        issue(OP_OP, 3'b000, 5'd4, 1'b0, 32'h00000077, 32'h0);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b0 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL no_write: we=%b cnt=%h required 0/%h", wb_reg_write_o, retired_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        ex_valid_i = 1'b1; ex_opcode_i = OP_OP; ex_funct3_i = 3'b000;
        ex_rd_i = 5'd11; ex_reg_write_i = 1'b1; ex_alu_result_i = 32'hAAAA0001; ex_pc_plus4_i = 32'h0;
        @(negedge clk_i);
        exp_cnt++;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd11 || wb_data_o !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL b2b_first: we=%b rd=%0d data=%h required 1/11/aaaa0001", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        ex_opcode_i = OP_JALR; ex_rd_i = 5'd12; ex_alu_result_i = 32'h0; ex_pc_plus4_i = 32'h00002008;
        @(negedge clk_i);
        exp_cnt++;
        ex_valid_i = 1'b0;
        checks++;
        if (wb_reg_write_o !== 1'b1 || wb_rd_o !== 5'd12 || wb_data_o !== 32'h00002008 || retired_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_jalr: we=%b rd=%0d data=%h cnt=%h required 1/12/00002008/%h", wb_reg_write_o, wb_rd_o, wb_data_o, retired_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_load_reset;
        issue(OP_LOAD, 3'b010, 5'd6, 1'b1, 32'h00000100, 32'h0);
        rst_i = 1'b1;
        load_return(32'h11223344);
        rst_i   = 1'b0;
        exp_cnt = 32'd0;
        checks++;
        if (wb_reg_write_o !== 1'b0 || wb_rd_o !== 5'd0 || wb_data_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_load_wb: we=%b rd=%0d data=%h required 0/0/0", wb_reg_write_o, wb_rd_o, wb_data_o);
        end
        checks++;
        if (ex_ready_o !== 1'b1 || load_pending_o !== 1'b0 || retired_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_load_ctl: ready=%b pend=%b cnt=%h required 1/0/0", ex_ready_o, load_pending_o, retired_cnt_o);
        end
    endtask

    task automatic test_wrap;
        // Counter is held at all-ones across an idle edge, then released
        force dut.r_retired_cnt = 32'hFFFFFFFF;
        @(negedge clk_i);
        release dut.r_retired_cnt;
        checks++;
        if (retired_cnt_o !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL wrap_preload: cnt=%h required ffffffff", retired_cnt_o);
        end
        issue(OP_OP, 3'b000, 5'd2, 1'b1, 32'h00000042, 32'h0);
        checks++;
        if (retired_cnt_o !== 32'd0 || wb_reg_write_o !== 1'b1 || wb_data_o !== 32'h00000042) begin
            failures++;
            $display("FAIL wrap: cnt=%h we=%b data=%h required 0/1/00000042", retired_cnt_o, wb_reg_write_o, wb_data_o);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        exp_cnt         = 32'd0;
        rst_i           = 1'b1;
        ex_valid_i      = 1'b0;
        ex_opcode_i     = 7'd0;
        ex_funct3_i     = 3'd0;
        ex_rd_i         = 5'd0;
        ex_reg_write_i  = 1'b0;
        ex_alu_result_i = 32'd0;
        ex_pc_plus4_i   = 32'd0;
        dmem_rvalid_i   = 1'b0;
        dmem_rdata_i    = 32'd0;
        @(negedge clk_i);

        test_reset();
        test_alu();
        test_load_byte();
        test_load_align();
        test_jal_rd0();
        test_back_to_back();
        test_load_reset();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
